// File: rtl/tmds_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmds_rx_pkg
// Description : Shared constants, FSM state type and token test for the
//               TMDS receive deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package tmds_rx_pkg;

    localparam int ALIGN_POSITIONS = 10;

    localparam logic [9:0] CTRL_TOKEN_0 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_1 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_2 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_3 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == CTRL_TOKEN_0) || (word == CTRL_TOKEN_1) ||
               (word == CTRL_TOKEN_2) || (word == CTRL_TOKEN_3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iserdes_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : iserdes_gearbox
// Description : 2:10 gearbox - bit-pair history, word phase counter and
//               alignment-selected word capture.
// Revision    : 1.0 - initial release
// ============================================================================
module iserdes_gearbox
    import tmds_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data_rise_i,
    input  logic       data_fall_i,
    input  logic       slip_i,
    output logic [9:0] par_data_o,
    output logic       par_valid_o,
    output logic [3:0] align_pos_o
);

    localparam logic [3:0] LAST_POS = 4'(ALIGN_POSITIONS - 1);

    logic [11:0] hist_q;
    logic [2:0]  word_cnt_q;
    logic [2:0]  word_cnt_d;
    logic [9:0]  par_data_q;
    logic        par_valid_q;
    logic [3:0]  align_pos_q;
    logic [3:0]  align_pos_d;

    logic [2:0]  w_word_phase;
    logic [9:0]  w_slice;
    logic        w_capture;

    // align_pos = {word_phase, bit_phase}; bit_phase 1 starts the word on a fall bit
    assign w_word_phase = align_pos_q[3:1];
    assign w_slice      = align_pos_q[0] ? hist_q[10:1] : hist_q[11:2];
    assign w_capture    = (word_cnt_q == w_word_phase);

    always_comb begin
        word_cnt_d  = (word_cnt_q == 3'd4) ? 3'd0 : word_cnt_q + 3'd1;
        align_pos_d = align_pos_q;
        if (slip_i) begin
            align_pos_d = (align_pos_q == LAST_POS) ? 4'd0 : align_pos_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q      <= '0;
            word_cnt_q  <= '0;
            par_data_q  <= '0;
            par_valid_q <= 1'b0;
            align_pos_q <= '0;
        end else begin
            hist_q      <= {data_fall_i, data_rise_i, hist_q[11:2]};
            word_cnt_q  <= word_cnt_d;
            par_valid_q <= w_capture;
            align_pos_q <= align_pos_d;
            if (w_capture) begin
                par_data_q <= w_slice;
            end
        end
    end

    assign par_data_o  = par_data_q;
    assign par_valid_o = par_valid_q;
    assign align_pos_o = align_pos_q;

endmodule
`default_nettype wire

// File: rtl/iserdese_hc.sv
`default_nettype none
// ============================================================================
// Module      : iserdese_hc
// Description : TMDS 10-bit receive deserializer with autonomous character
//               alignment by control-token hunting.
// Revision    : 1.0 - initial release
// ============================================================================
module iserdese_hc
    import tmds_rx_pkg::*;
#(
    parameter int TOKEN_COUNT = 8,
    parameter int WINDOW      = 4096,
    parameter int MISS_W      = $clog2(WINDOW + 1)
) (
    input  logic       ddr_bit_clock,
    input  logic       rst,
    input  logic       data_rise,
    input  logic       data_fall,
    input  logic       realign,
    output logic [9:0] par_data,
    output logic       par_valid,
    output logic       locked,
    output logic [3:0] align_pos
);

    localparam int                TOK_W     = $clog2(TOKEN_COUNT + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(WINDOW - 1);
    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(TOKEN_COUNT - 1);

    rx_state_e         state_q;
    rx_state_e         state_d;
    logic [MISS_W-1:0] miss_cnt_q;
    logic [MISS_W-1:0] miss_cnt_d;
    logic [TOK_W-1:0]  tok_cnt_q;
    logic [TOK_W-1:0]  tok_cnt_d;
    logic              locked_q;

    logic              w_slip;
    logic              w_token;
    logic [9:0]        w_par_data;
    logic              w_par_valid;
    logic [3:0]        w_align_pos;

    iserdes_gearbox u_gearbox (
        .clk         (ddr_bit_clock),
        .rst         (rst),
        .data_rise_i (data_rise),
        .data_fall_i (data_fall),
        .slip_i      (w_slip),
        .par_data_o  (w_par_data),
        .par_valid_o (w_par_valid),
        .align_pos_o (w_align_pos)
    );

    assign w_token = is_ctrl_token(w_par_data);

    always_ff @(posedge ddr_bit_clock) begin
        if (rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (realign) begin
            state_d = SEARCH;
        end else if (w_par_valid) begin
            case (state_q)
                SEARCH: begin
                    if (w_token) begin
                        if (TOKEN_COUNT <= 1) state_d = LOCKED;
                        else                  state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!w_token)                  state_d = SEARCH;
                    else if (tok_cnt_q == TOK_LAST) state_d = LOCKED;
                end
                LOCKED: begin
                    if (!w_token && (miss_cnt_q == MISS_LAST)) state_d = SEARCH;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Realign takes precedence, so a coincident window expiry yields one slip only
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        tok_cnt_d  = tok_cnt_q;
        w_slip     = 1'b0;
        if (realign) begin
            w_slip     = 1'b1;
            miss_cnt_d = '0;
            tok_cnt_d  = '0;
        end else if (w_par_valid) begin
            case (state_q)
                SEARCH: begin
                    if (w_token) begin
                        tok_cnt_d  = TOK_W'(1);
                        miss_cnt_d = '0;
                    end else if (miss_cnt_q == MISS_LAST) begin
                        w_slip     = 1'b1;
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MISS_W'(1);
                    end
                end
                CHECK: begin
                    if (w_token && (tok_cnt_q != TOK_LAST)) begin
                        tok_cnt_d = tok_cnt_q + TOK_W'(1);
                    end else begin
                        tok_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (w_token || (miss_cnt_q == MISS_LAST)) begin
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MISS_W'(1);
                    end
                end
                default: begin
                    miss_cnt_d = '0;
                    tok_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ddr_bit_clock) begin
        if (rst) begin
            miss_cnt_q <= '0;
            tok_cnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            tok_cnt_q  <= tok_cnt_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

    assign par_data  = w_par_data;
    assign par_valid = w_par_valid;
    assign locked    = locked_q;
    assign align_pos = w_align_pos;

endmodule
`default_nettype wire

// File: tb/tb_iserdese_hc.sv
`default_nettype none
// ============================================================================
// Module      : tb_iserdese_hc
// Description : Directed, table-driven bench for the TMDS receive deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iserdese_hc;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_rise;
    logic       data_fall;
    logic       realign;
    logic [9:0] par_data;
    logic       par_valid;
    logic       locked;
    logic [3:0] align_pos;

    always #5 clk = ~clk;

    iserdese_hc #(
        .TOKEN_COUNT (8),
        .WINDOW      (16)
    ) dut (
        .ddr_bit_clock (clk),
        .rst           (rst),
        .data_rise     (data_rise),
        .data_fall     (data_fall),
        .realign       (realign),
        .par_data      (par_data),
        .par_valid     (par_valid),
        .locked        (locked),
        .align_pos     (align_pos)
    );

    typedef struct {
        logic [9:0] ch;
        logic       exp_valid;
        logic [9:0] exp_data;
        logic       exp_locked;
        logic [3:0] exp_ap;
    } vec_t;

    vec_t       vecs[45];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         q[$];
    logic [9:0] cur_char;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_char(input logic [9:0] c);
        for (int i = 0; i < 10; i++) q.push_back(c[i]);
    endtask

    // One bit pair per clock, earliest stream bit on the rise slot
    task automatic tick();
        if (q.size() < 2) push_char(cur_char);
        data_rise = q.pop_front();
        data_fall = q.pop_front();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        realign = 1'b0;
        repeat (n) begin
            data_rise = 1'($urandom);
            data_fall = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        q.delete();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 45; i++) begin
            cur_char = vecs[i].ch;
            tick();
            check($sformatf("%s_vec%0d", tag, i + 1),
                  {16'd0, par_valid, par_data, locked, align_pos},
                  {16'd0, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_locked, vecs[i].exp_ap});
        end
    endtask

    initial begin
        int         prev_ap;
        int         seg;
        int         tok_seen;
        int         n_hit;
        bit         got_lock;
        bit         prev_valid;
        bit         done;
        logic [9:0] tok_ab;

        // Cycle k after reset: stale all-zero word at k=1, then 354 every 5 clocks
        for (int k = 1; k <= 45; k++) begin
            vecs[k-1].ch         = 10'h354;
            vecs[k-1].exp_valid  = (k % 5 == 1);
            vecs[k-1].exp_data   = (k >= 6) ? 10'h354 : 10'h000;
            vecs[k-1].exp_locked = (k >= 42);
            vecs[k-1].exp_ap     = 4'd0;
        end

        rst = 1'b1; realign = 1'b0; data_rise = 1'b0; data_fall = 1'b0;
        cur_char = 10'h354;

        do_reset(3);
        check("reset_par_valid", 32'(par_valid), 32'd0);
        check("reset_locked",    32'(locked),    32'd0);
        check("reset_align_pos", 32'(align_pos), 32'd0);
        check("reset_par_data",  32'(par_data),  32'd0);

        run_table("aligned");

        // Reset in the middle of CHECK with five tokens counted
        do_reset(2);
        cur_char = 10'h354;
        repeat (27) tick();
        check("midcheck_not_locked", 32'(locked), 32'd0);
        rst = 1'b1;
        data_rise = 1'b1; data_fall = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        check("midrst_par_valid", 32'(par_valid), 32'd0);
        check("midrst_locked",    32'(locked),    32'd0);
        check("midrst_align_pos", 32'(align_pos), 32'd0);
        check("midrst_par_data",  32'(par_data),  32'd0);
        run_table("relock_after_rst");

        // Stream of 0AB whose characters start at stream bit 7 -> only align_pos 9 fits
        do_reset(3);
        tok_ab = 10'h0AB;
        for (int i = 3; i < 10; i++) q.push_back(tok_ab[i]);
        cur_char = 10'h0AB;
        prev_ap = 0; seg = 0; tok_seen = 0; got_lock = 0; prev_valid = 0;
        for (int c = 0; c < 2000 && !got_lock; c++) begin
            tick();
            if (int'(align_pos) != prev_ap) begin
                check("slip_spacing", 32'(seg), 32'd16);
                check("slip_step", 32'(align_pos), 32'((prev_ap + 1) % 10));
                prev_ap = int'(align_pos);
                seg     = 0;
            end
            if (locked) begin
                got_lock = 1;
                check("lock_token_count", 32'(tok_seen), 32'd8);
                check("lock_one_clk_after_strobe", 32'(prev_valid), 32'd1);
            end
            if (par_valid) begin
                seg++;
                if (align_pos == 4'd9 && par_data == 10'h0AB) tok_seen++;
            end
            prev_valid = par_valid;
        end
        check("misalign_locked", 32'(got_lock),  32'd1);
        check("misalign_pos",    32'(align_pos), 32'd9);
        check("misalign_word",   32'(par_data),  32'h0AB);

        // Sixteen non-token characters drop lock without slipping
        repeat (16) push_char(10'h1F0);
        n_hit = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (par_valid && par_data == 10'h1F0) begin
                n_hit++;
                if (n_hit == 16) begin
                    done = 1;
                    check("lol_still_locked_at_16th", 32'(locked), 32'd1);
                    tick();
                    check("lol_unlocked", 32'(locked), 32'd0);
                    check("lol_align_kept", 32'(align_pos), 32'd9);
                end
            end
        end
        check("lol_seen_16", 32'(n_hit), 32'd16);

        n_hit = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (par_valid && par_data == 10'h0AB) begin
                n_hit++;
                if (n_hit == 8) begin
                    done = 1;
                    check("relock_pre", 32'(locked), 32'd0);
                    tick();
                    check("relock", 32'(locked), 32'd1);
                end
            end
        end
        check("relock_seen_8", 32'(n_hit), 32'd8);

        // Realign from position 9 wraps to 0 and restarts the search window
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("realign_unlock", 32'(locked),    32'd0);
        check("realign_wrap",   32'(align_pos), 32'd0);
        seg = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (align_pos != 4'd0) begin
                done = 1;
                check("realign_search_spacing", 32'(seg), 32'd16);
                check("realign_search_step", 32'(align_pos), 32'd1);
            end
            if (par_valid) seg++;
        end
        check("realign_search_slip_seen", 32'(done), 32'd1);
        check("realign_still_unlocked", 32'(locked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
